// File: rtl/multicycle_control_if.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_if
// Brief    : Control bundle between the multicycle controller and its datapath
// Revision : 1.0  initial release
// ============================================================================
interface multicycle_control_if;
    logic [5:0] opcode;
    logic       zero;
    logic       pc_en;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic [3:0] state;
    logic       instr_done;
    logic       illegal;

    // Controller side
    modport master (
        input  opcode, zero,
        output pc_en, ir_write, i_or_d, mem_write, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, state,
               instr_done, illegal
    );

    // Datapath side
    modport slave (
        output opcode, zero,
        input  pc_en, ir_write, i_or_d, mem_write, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, state,
               instr_done, illegal
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Brief    : Moore FSM controller for a multicycle MIPS-subset datapath
// Revision : 1.0  initial release
// ============================================================================
module multicycle_control (
    input  wire logic            clock,
    input  wire logic            reset,
    multicycle_control_if.master ctrl
);
    localparam logic [3:0] c_FETCH    = 4'd0;
    localparam logic [3:0] c_DECODE   = 4'd1;
    localparam logic [3:0] c_MEMADR   = 4'd2;
    localparam logic [3:0] c_MEMREAD  = 4'd3;
    localparam logic [3:0] c_MEMWB    = 4'd4;
    localparam logic [3:0] c_MEMWRITE = 4'd5;
    localparam logic [3:0] c_EXECUTE  = 4'd6;
    localparam logic [3:0] c_ALUWB    = 4'd7;
    localparam logic [3:0] c_BRANCH   = 4'd8;
    localparam logic [3:0] c_ADDIEXEC = 4'd9;
    localparam logic [3:0] c_ADDIWB   = 4'd10;
    localparam logic [3:0] c_JUMP     = 4'd11;

    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    logic [3:0] r_state;
    logic [3:0] w_next_state;
    logic [3:0] w_state;

    logic       w_pc_write;
    logic       w_branch;
    logic       w_ir_write;
    logic       w_i_or_d;
    logic       w_mem_write;
    logic       w_reg_write;
    logic       w_reg_dst;
    logic       w_mem_to_reg;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_alu_op;
    logic [1:0] w_pc_src;
    logic       w_instr_done;
    logic       w_illegal;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = c_FETCH;
        case (r_state)
            c_FETCH:    w_next_state = c_DECODE;
            c_DECODE: begin
                case (ctrl.opcode)
                    c_OP_LW, c_OP_SW: w_next_state = c_MEMADR;
                    c_OP_RTYPE:       w_next_state = c_EXECUTE;
                    c_OP_BEQ:         w_next_state = c_BRANCH;
                    c_OP_ADDI:        w_next_state = c_ADDIEXEC;
                    c_OP_J:           w_next_state = c_JUMP;
                    default:          w_next_state = c_FETCH;
                endcase
            end
            c_MEMADR: begin
                if (ctrl.opcode == c_OP_LW) begin
                    w_next_state = c_MEMREAD;
                end else if (ctrl.opcode == c_OP_SW) begin
                    w_next_state = c_MEMWRITE;
                end else begin
                    w_next_state = c_FETCH;
                end
            end
            c_MEMREAD:  w_next_state = c_MEMWB;
            c_EXECUTE:  w_next_state = c_ALUWB;
            c_ADDIEXEC: w_next_state = c_ADDIWB;
            default:    w_next_state = c_FETCH;
        endcase
    end

    // While reset is held the outputs present FETCH decodes.
    assign w_state = reset ? c_FETCH : r_state;

    always_comb begin
        w_pc_write   = 1'b0;
        w_branch     = 1'b0;
        w_ir_write   = 1'b0;
        w_i_or_d     = 1'b0;
        w_mem_write  = 1'b0;
        w_reg_write  = 1'b0;
        w_reg_dst    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_alu_src_a  = 1'b0;
        w_alu_src_b  = 2'b00;
        w_alu_op     = 2'b00;
        w_pc_src     = 2'b00;
        w_instr_done = 1'b0;
        w_illegal    = 1'b0;
        case (w_state)
            c_FETCH: begin
                w_ir_write  = 1'b1;
                w_pc_write  = 1'b1;
                w_alu_src_b = 2'b01;
            end
            c_DECODE: begin
                w_alu_src_b = 2'b11;
                case (ctrl.opcode)
                    c_OP_LW, c_OP_SW, c_OP_RTYPE,
                    c_OP_BEQ, c_OP_ADDI, c_OP_J: w_illegal = 1'b0;
                    default:                     w_illegal = 1'b1;
                endcase
            end
            c_MEMADR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
            end
            c_MEMREAD: begin
                w_i_or_d = 1'b1;
            end
            c_MEMWB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
                w_instr_done = 1'b1;
            end
            c_MEMWRITE: begin
                w_i_or_d     = 1'b1;
                w_mem_write  = 1'b1;
                w_instr_done = 1'b1;
            end
            c_EXECUTE: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = 2'b10;
            end
            c_ALUWB: begin
                w_reg_write  = 1'b1;
                w_reg_dst    = 1'b1;
                w_instr_done = 1'b1;
            end
            c_BRANCH: begin
                w_alu_src_a  = 1'b1;
                w_alu_op     = 2'b01;
                w_pc_src     = 2'b01;
                w_branch     = 1'b1;
                w_instr_done = 1'b1;
            end
            c_ADDIEXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
            end
            c_ADDIWB: begin
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
            end
            c_JUMP: begin
                w_pc_write   = 1'b1;
                w_pc_src     = 2'b10;
                w_instr_done = 1'b1;
            end
            default: begin
                w_illegal = 1'b0;
            end
        endcase
    end

    assign ctrl.pc_en      = (w_pc_write | (w_branch & ctrl.zero)) & ~reset;
    assign ctrl.ir_write   = w_ir_write   & ~reset;
    assign ctrl.mem_write  = w_mem_write  & ~reset;
    assign ctrl.reg_write  = w_reg_write  & ~reset;
    assign ctrl.instr_done = w_instr_done & ~reset;
    assign ctrl.illegal    = w_illegal    & ~reset;
    assign ctrl.i_or_d     = w_i_or_d;
    assign ctrl.reg_dst    = w_reg_dst;
    assign ctrl.mem_to_reg = w_mem_to_reg;
    assign ctrl.alu_src_a  = w_alu_src_a;
    assign ctrl.alu_src_b  = w_alu_src_b;
    assign ctrl.alu_op     = w_alu_op;
    assign ctrl.pc_src     = w_pc_src;
    assign ctrl.state      = w_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control
// Brief    : Scoreboard bench for multicycle_control with directed vectors
// Revision : 1.0  initial release
// ============================================================================
module tb_multicycle_control;
    // Control word: {pc_en, ir_write, i_or_d, mem_write, reg_write, reg_dst,
    //                mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src,
    //                instr_done, illegal}
    localparam logic [15:0] c_W_RST      = 16'h0040;
    localparam logic [15:0] c_W_FETCH    = 16'hC040;
    localparam logic [15:0] c_W_DECODE   = 16'h00C0;
    localparam logic [15:0] c_W_DEC_ILL  = 16'h00C1;
    localparam logic [15:0] c_W_MEMADR   = 16'h0180;
    localparam logic [15:0] c_W_MEMREAD  = 16'h2000;
    localparam logic [15:0] c_W_MEMWB    = 16'h0A02;
    localparam logic [15:0] c_W_MEMWRITE = 16'h3002;
    localparam logic [15:0] c_W_EXECUTE  = 16'h0120;
    localparam logic [15:0] c_W_ALUWB    = 16'h0C02;
    localparam logic [15:0] c_W_BR_Z0    = 16'h0116;
    localparam logic [15:0] c_W_BR_Z1    = 16'h8116;
    localparam logic [15:0] c_W_ADDIEXEC = 16'h0180;
    localparam logic [15:0] c_W_ADDIWB   = 16'h0802;
    localparam logic [15:0] c_W_JUMP     = 16'h800A;

    typedef struct {
        logic [3:0]  st;
        logic [15:0] ctl;
        int          id;
    } exp_t;

    logic clock;
    logic reset;
    int   checks;
    int   errors;
    int   cyc_id;
    exp_t exp_q[$];

    multicycle_control_if bus ();

    multicycle_control dut (
        .clock (clock),
        .reset (reset),
        .ctrl  (bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [15:0] pack_ctl();
        return {bus.pc_en, bus.ir_write, bus.i_or_d, bus.mem_write,
                bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a,
                bus.alu_src_b, bus.alu_op, bus.pc_src, bus.instr_done,
                bus.illegal};
    endfunction

    // One cycle of stimulus; the expected response is queued for the monitor.
    task automatic cyc(input logic rst, input logic [5:0] op, input logic z,
                       input logic [3:0] est, input logic [15:0] ectl);
        exp_t e;
        @(posedge clock);
        #1;
        reset      = rst;
        bus.opcode = op;
        bus.zero   = z;
        e.st  = est;
        e.ctl = ectl;
        e.id  = cyc_id;
        exp_q.push_back(e);
        cyc_id++;
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [15:0] got;
            e   = exp_q.pop_front();
            got = pack_ctl();
            checks++;
            if (bus.state !== e.st) begin
                errors++;
                $display("FAIL state cyc=%0d got=%0d exp=%0d", e.id, bus.state, e.st);
            end
            checks++;
            if (got !== e.ctl) begin
                errors++;
                $display("FAIL ctrl cyc=%0d got=%h exp=%h", e.id, got, e.ctl);
            end
            checks++;
            if ($countones({bus.mem_write, bus.reg_write, bus.ir_write}) > 1) begin
                errors++;
                $display("FAIL write_excl cyc=%0d got=%b exp=at_most_one",
                         e.id, {bus.mem_write, bus.reg_write, bus.ir_write});
            end
        end
    end

    initial begin
        checks     = 0;
        errors     = 0;
        cyc_id     = 0;
        reset      = 1'b1;
        bus.opcode = 6'b000000;
        bus.zero   = 1'b0;

        // Reset for two cycles
        cyc(1'b1, 6'b100011, 1'b0, 4'd0, c_W_RST);
        cyc(1'b1, 6'b100011, 1'b0, 4'd0, c_W_RST);

        // lw
        cyc(1'b0, 6'b100011, 1'b0, 4'd0, c_W_FETCH);
        cyc(1'b0, 6'b100011, 1'b0, 4'd1, c_W_DECODE);
        cyc(1'b0, 6'b100011, 1'b0, 4'd2, c_W_MEMADR);
        cyc(1'b0, 6'b100011, 1'b0, 4'd3, c_W_MEMREAD);
        cyc(1'b0, 6'b100011, 1'b0, 4'd4, c_W_MEMWB);

        // sw
        cyc(1'b0, 6'b101011, 1'b0, 4'd0, c_W_FETCH);
        cyc(1'b0, 6'b101011, 1'b0, 4'd1, c_W_DECODE);
        cyc(1'b0, 6'b101011, 1'b0, 4'd2, c_W_MEMADR);
        cyc(1'b0, 6'b101011, 1'b0, 4'd5, c_W_MEMWRITE);

        // beq taken, then not taken
        cyc(1'b0, 6'b000100, 1'b1, 4'd0, c_W_FETCH);
        cyc(1'b0, 6'b000100, 1'b1, 4'd1, c_W_DECODE);
        cyc(1'b0, 6'b000100, 1'b1, 4'd8, c_W_BR_Z1);
        cyc(1'b0, 6'b000100, 1'b0, 4'd0, c_W_FETCH);
        cyc(1'b0, 6'b000100, 1'b0, 4'd1, c_W_DECODE);
        cyc(1'b0, 6'b000100, 1'b0, 4'd8, c_W_BR_Z0);

        // R-type then addi back-to-back
        cyc(1'b0, 6'b000000, 1'b0, 4'd0, c_W_FETCH);
        cyc(1'b0, 6'b000000, 1'b0, 4'd1, c_W_DECODE);
        cyc(1'b0, 6'b000000, 1'b0, 4'd6, c_W_EXECUTE);
        cyc(1'b0, 6'b000000, 1'b0, 4'd7, c_W_ALUWB);
        cyc(1'b0, 6'b001000, 1'b0, 4'd0, c_W_FETCH);
        cyc(1'b0, 6'b001000, 1'b0, 4'd1, c_W_DECODE);
        cyc(1'b0, 6'b001000, 1'b0, 4'd9, c_W_ADDIEXEC);
        cyc(1'b0, 6'b001000, 1'b0, 4'd10, c_W_ADDIWB);

        // jump
        cyc(1'b0, 6'b000010, 1'b0, 4'd0, c_W_FETCH);
        cyc(1'b0, 6'b000010, 1'b0, 4'd1, c_W_DECODE);
        cyc(1'b0, 6'b000010, 1'b0, 4'd11, c_W_JUMP);

        // illegal opcode: two cycles, then straight back to FETCH
        cyc(1'b0, 6'b111111, 1'b0, 4'd0, c_W_FETCH);
        cyc(1'b0, 6'b111111, 1'b0, 4'd1, c_W_DEC_ILL);
        cyc(1'b0, 6'b111111, 1'b0, 4'd0, c_W_FETCH);
        cyc(1'b0, 6'b111111, 1'b0, 4'd1, c_W_DEC_ILL);

        // lw aborted by reset raised during MEMREAD
        cyc(1'b0, 6'b100011, 1'b0, 4'd0, c_W_FETCH);
        cyc(1'b0, 6'b100011, 1'b0, 4'd1, c_W_DECODE);
        cyc(1'b0, 6'b100011, 1'b0, 4'd2, c_W_MEMADR);
        cyc(1'b0, 6'b100011, 1'b0, 4'd3, c_W_MEMREAD);
        @(negedge clock);
        #1;
        reset = 1'b1;
        cyc(1'b1, 6'b100011, 1'b0, 4'd0, c_W_RST);
        cyc(1'b0, 6'b100011, 1'b0, 4'd0, c_W_FETCH);
        cyc(1'b0, 6'b100011, 1'b0, 4'd1, c_W_DECODE);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clock);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending exp=0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameters: none.
REQ-002 clock  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clock.
REQ-004 opcode  input  6  instr[31:26] from instruction register; valid from DECODE onward.
REQ-005 zero  input  1  ALU zero flag, combinational, valid in BRANCH state.
REQ-006 pc_en  output  1  PC load enable = pc_write | (branch & zero).
REQ-007 ir_write  output  1  instruction register load enable.
REQ-008 i_or_d  output  1  memory address select: 0 = PC, 1 = ALU result register.
REQ-009 mem_write  output  1  shared instruction/data memory write enable.
REQ-010 reg_write  output  1  register file write enable.
REQ-011 reg_dst  output  1  write register select: 0 = rt, 1 = rd.
REQ-012 mem_to_reg  output  1  write-back select: 0 = ALU result register, 1 = memory data register.
REQ-013 alu_src_a  output  1  ALU A select: 0 = PC, 1 = register A.
REQ-014 alu_src_b  output  2  ALU B select: 00 = reg B, 01 = constant 4, 10 = sign-ext imm, 11 = sign-ext imm << 2.
REQ-015 alu_op  output  2  to ALU_decoder: 00 add, 01 subtract, 10 decode funct.
REQ-016 pc_src  output  2  PC next select: 00 = ALU result, 01 = ALU result register (branch target), 10 = jump address.
REQ-017 state  output  4  current state encoding, for debug/monitor.
REQ-018 instr_done  output  1  one-cycle pulse in final state of each instruction.
REQ-019 illegal  output  1  one-cycle pulse when DECODE sees an unsupported opcode.

Function
REQ-020 Moore FSM; all outputs are combinational decodes of state only, except pc_en (uses zero); any output not listed for a state SHALL be 0.
REQ-021 Encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11; codes 12-15 unreachable and SHALL return to FETCH on the next edge.
REQ-022 FETCH: ir_write=1, pc_write=1, alu_src_b=01, i_or_d=0, alu_op=00, pc_src=00; next DECODE.
REQ-023 DECODE: alu_src_b=11, alu_op=00; next by opcode: 100011/101011 -> MEMADR, 000000 -> EXECUTE, 000100 -> BRANCH, 001000 -> ADDIEXEC, 000010 -> JUMP, other -> FETCH with illegal=1.
REQ-024 MEMADR: alu_src_a=1, alu_src_b=10; next MEMREAD if opcode=100011, MEMWRITE if 101011.
REQ-025 MEMREAD: i_or_d=1; next MEMWB.
REQ-026 MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1; next FETCH.
REQ-027 MEMWRITE: i_or_d=1, mem_write=1, instr_done=1; next FETCH.
REQ-028 EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10; next ALUWB.
REQ-029 ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1; next FETCH.
REQ-030 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=1, instr_done=1; next FETCH regardless of zero.
REQ-031 ADDIEXEC: alu_src_a=1, alu_src_b=10, alu_op=00; next ADDIWB.
REQ-032 ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1; next FETCH.
REQ-033 JUMP: pc_write=1, pc_src=10, instr_done=1; next FETCH.
REQ-034 Latency in cycles, FETCH inclusive: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3; illegal opcode 2 with no write enable asserted.
REQ-035 At most one of mem_write, reg_write, ir_write SHALL be 1 in any cycle.

Reset
REQ-036 reset=1 at a rising edge SHALL force state=FETCH, overriding any transition, including mid-instruction.
REQ-037 While reset=1, pc_en, ir_write, mem_write, reg_write, instr_done, illegal SHALL be forced 0; other outputs take FETCH values.
REQ-038 First FETCH operations occur in the first cycle after reset deasserts.

Verification
REQ-039 Reset 2 cycles then release, opcode=100011 -> states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4; instr_done pulses once.
REQ-040 opcode=101011 -> states 0,1,2,5,0; mem_write=1 only in state 5 with i_or_d=1; reg_write never 1.
REQ-041 opcode=000100 with zero=1 -> pc_en=1 in state 8; repeat with zero=0 -> pc_en=0 in state 8; both return to FETCH after 3 cycles.
REQ-042 opcode=000000 then 001000 back-to-back -> 0,1,6,7,0,1,9,10,0; alu_op=10 in 6, reg_dst=1 in 7, reg_dst=0 in 10.
REQ-043 opcode=111111 -> illegal=1 in DECODE, next state FETCH, no write enable asserted during instruction.
REQ-044 Assert reset while state=3 (lw MEMREAD) -> next state 0, reg_write never asserted for that lw.
